// File: rtl/p4_out_pkt_collector.sv
// p4_out_pkt_collector
//   Receive end of the vitis_net_p4 pipeline. Forwards the P4 output stream through a
//   1-deep register slice, pairs each packet with its metadata word and emits one
//   descriptor per packet (byte length, beat count, metadata, error flags). Also keeps
//   packet and metadata-drop statistics.
// Ports
//   clk, rst                      single rising-edge clock, synchronous active-high reset
//   s_axis_*                      input stream from the P4 IP (tdata/tkeep/tvalid/tlast/tready)
//   user_metadata_in(_valid)      metadata word with a 1-cycle push strobe (no backpressure)
//   m_axis_*                      forwarded stream, one cycle behind the accepted beat
//   desc_valid/desc_ready         descriptor handshake
//   desc_len/beats/meta/err       descriptor payload; err = {saturated, no meta, bad tkeep}
//   pkt_active                    high while inside a multi-beat packet
//   stat_pkt_count                descriptors consumed (wrapping)
//   stat_meta_drop                metadata words lost to a full FIFO (saturating)
module p4_out_pkt_collector #(
  parameter int TDATA_NUM_BYTES      = 64,
  parameter int USER_META_DATA_WIDTH = 9,
  parameter int LEN_WIDTH            = 16,
  parameter int META_FIFO_DEPTH      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [TDATA_NUM_BYTES*8-1:0]    s_axis_tdata,
  input  logic [TDATA_NUM_BYTES-1:0]      s_axis_tkeep,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  input  logic [USER_META_DATA_WIDTH-1:0] user_metadata_in,
  input  logic                            user_metadata_in_valid,
  output logic [TDATA_NUM_BYTES*8-1:0]    m_axis_tdata,
  output logic [TDATA_NUM_BYTES-1:0]      m_axis_tkeep,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic                            desc_valid,
  input  logic                            desc_ready,
  output logic [LEN_WIDTH-1:0]            desc_len,
  output logic [LEN_WIDTH-1:0]            desc_beats,
  output logic [USER_META_DATA_WIDTH-1:0] desc_meta,
  output logic [2:0]                      desc_err,
  output logic                            pkt_active,
  output logic [31:0]                     stat_pkt_count,
  output logic [15:0]                     stat_meta_drop
);

  localparam int KW  = TDATA_NUM_BYTES;
  localparam int DW  = TDATA_NUM_BYTES * 8;
  localparam int MW  = USER_META_DATA_WIDTH;
  localparam int LW  = LEN_WIDTH;
  localparam int PCW = $clog2(KW + 1);
  localparam int AW  = $clog2(META_FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_e;

  // Number of set bits in a tkeep word.
  function automatic logic [PCW-1:0] popcount(input logic [KW-1:0] k);
    logic [PCW-1:0] c;
    c = '0;
    for (int i = 0; i < KW; i++) c = c + PCW'(k[i]);
    return c;
  endfunction

  // True when tkeep has the form 2^k-1 (including all-zero and all-ones).
  function automatic logic keep_contig(input logic [KW-1:0] k);
    return ((k & (k + KW'(1))) == '0);
  endfunction

  // Saturating add; bit LW of the result flags that the sum was clamped.
  function automatic logic [LW:0] sat_add(input logic [LW-1:0] a, input logic [LW-1:0] b);
    logic [LW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[LW]) return {1'b1, {LW{1'b1}}};
    else       return s;
  endfunction

  state_e            state_q, state_d;
  logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [DW-1:0]     m_data_q, m_data_d;
  logic [KW-1:0]     m_keep_q, m_keep_d;
  logic [LW-1:0]     len_q, len_d, beats_q, beats_d;
  logic              keep_err_q, keep_err_d, sat_err_q, sat_err_d;
  logic              desc_valid_q, desc_valid_d;
  logic [LW-1:0]     desc_len_q, desc_len_d, desc_beats_q, desc_beats_d;
  logic [MW-1:0]     desc_meta_q, desc_meta_d;
  logic [2:0]        desc_err_q, desc_err_d;
  logic [31:0]       pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [MW-1:0]     fifo_mem_q [META_FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       fifo_cnt_q, fifo_cnt_d;

  logic              beat_s, last_acc_s, fifo_empty_s, fifo_full_s;
  logic              pop_s, bypass_s, push_store_s, drop_s;
  logic [LW:0]       len_sum_s, beats_sum_s;

  // Input accept is blocked during reset and whenever the slice or descriptor cannot take a beat.
  assign s_axis_tready = !rst && (!m_valid_q || m_axis_tready) && (!desc_valid_q || desc_ready);
  assign beat_s        = s_axis_tvalid && s_axis_tready;
  assign last_acc_s    = beat_s && s_axis_tlast;

  assign fifo_empty_s  = (fifo_cnt_q == '0);
  assign fifo_full_s   = (fifo_cnt_q == (AW+1)'(META_FIFO_DEPTH));
  assign pop_s         = last_acc_s && !fifo_empty_s;
  // An empty FIFO at tlast hands the incoming word straight to the descriptor.
  assign bypass_s      = last_acc_s && fifo_empty_s && user_metadata_in_valid;
  assign push_store_s  = user_metadata_in_valid && !bypass_s && (!fifo_full_s || pop_s);
  assign drop_s        = user_metadata_in_valid && fifo_full_s && !pop_s;

  assign len_sum_s     = sat_add(len_q, LW'(popcount(s_axis_tkeep)));
  assign beats_sum_s   = sat_add(beats_q, LW'(1));

  // Next-state logic for FSM, slice, accumulators, descriptor, FIFO pointers and stats.
  always_comb begin
    state_d      = state_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    len_d        = len_q;
    beats_d      = beats_q;
    keep_err_d   = keep_err_q;
    sat_err_d    = sat_err_q;
    desc_valid_d = desc_valid_q;
    desc_len_d   = desc_len_q;
    desc_beats_d = desc_beats_q;
    desc_meta_d  = desc_meta_q;
    desc_err_d   = desc_err_q;
    pkt_cnt_d    = pkt_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_cnt_d   = fifo_cnt_q;

    if (beat_s) begin
      m_valid_d = 1'b1;
      m_last_d  = s_axis_tlast;
      m_data_d  = s_axis_tdata;
      m_keep_d  = s_axis_tkeep;
      if (s_axis_tlast) begin
        state_d      = IDLE;
        desc_valid_d = 1'b1;
        desc_len_d   = len_sum_s[LW-1:0];
        desc_beats_d = beats_sum_s[LW-1:0];
        desc_err_d   = {sat_err_q || len_sum_s[LW] || beats_sum_s[LW],
                        fifo_empty_s && !user_metadata_in_valid,
                        keep_err_q || !keep_contig(s_axis_tkeep)};
        if (!fifo_empty_s)              desc_meta_d = fifo_mem_q[rd_ptr_q];
        else if (user_metadata_in_valid) desc_meta_d = user_metadata_in;
        else                            desc_meta_d = '0;
        len_d      = '0;
        beats_d    = '0;
        keep_err_d = 1'b0;
        sat_err_d  = 1'b0;
      end else begin
        state_d    = BODY;
        len_d      = len_sum_s[LW-1:0];
        beats_d    = beats_sum_s[LW-1:0];
        keep_err_d = keep_err_q || !keep_contig(s_axis_tkeep);
        sat_err_d  = sat_err_q || len_sum_s[LW] || beats_sum_s[LW];
      end
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end

    if (!last_acc_s && desc_ready) desc_valid_d = 1'b0;
    else                           desc_valid_d = desc_valid_d;

    if (desc_valid_q && desc_ready) pkt_cnt_d = pkt_cnt_q + 32'd1;
    else                            pkt_cnt_d = pkt_cnt_q;

    if (drop_s && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    else                                    drop_cnt_d = drop_cnt_q;

    if (push_store_s) wr_ptr_d = wr_ptr_q + AW'(1);
    else              wr_ptr_d = wr_ptr_q;
    if (pop_s) rd_ptr_d = rd_ptr_q + AW'(1);
    else       rd_ptr_d = rd_ptr_q;

    case ({push_store_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + (AW+1)'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - (AW+1)'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // State registers with synchronous reset; a partial packet is discarded here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      len_q        <= '0;
      beats_q      <= '0;
      keep_err_q   <= 1'b0;
      sat_err_q    <= 1'b0;
      desc_valid_q <= 1'b0;
      desc_len_q   <= '0;
      desc_beats_q <= '0;
      desc_meta_q  <= '0;
      desc_err_q   <= 3'b000;
      pkt_cnt_q    <= 32'd0;
      drop_cnt_q   <= 16'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      len_q        <= len_d;
      beats_q      <= beats_d;
      keep_err_q   <= keep_err_d;
      sat_err_q    <= sat_err_d;
      desc_valid_q <= desc_valid_d;
      desc_len_q   <= desc_len_d;
      desc_beats_q <= desc_beats_d;
      desc_meta_q  <= desc_meta_d;
      desc_err_q   <= desc_err_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  // Metadata FIFO storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < META_FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else if (push_store_s) begin
      fifo_mem_q[wr_ptr_q] <= user_metadata_in;
    end
  end

  assign m_axis_tdata   = m_data_q;
  assign m_axis_tkeep   = m_keep_q;
  assign m_axis_tvalid  = m_valid_q;
  assign m_axis_tlast   = m_last_q;
  assign desc_valid     = desc_valid_q;
  assign desc_len       = desc_len_q;
  assign desc_beats     = desc_beats_q;
  assign desc_meta      = desc_meta_q;
  assign desc_err       = desc_err_q;
  assign pkt_active     = (state_q == BODY);
  assign stat_pkt_count = pkt_cnt_q;
  assign stat_meta_drop = drop_cnt_q;

endmodule

// File: tb/tb_p4_out_pkt_collector.sv
// Directed bench for p4_out_pkt_collector: linear steps, immediate-assertion checks,
// scoreboard of forwarded beats while m_axis_tready toggles.
module tb_p4_out_pkt_collector;

  logic         clk;
  logic         rst;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [8:0]   user_metadata_in;
  logic         user_metadata_in_valid;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic         desc_valid;
  logic         desc_ready;
  logic [15:0]  desc_len;
  logic [15:0]  desc_beats;
  logic [8:0]   desc_meta;
  logic [2:0]   desc_err;
  logic         pkt_active;
  logic [31:0]  stat_pkt_count;
  logic [15:0]  stat_meta_drop;

  int checks   = 0;
  int failures = 0;
  bit tog_en   = 1'b0;
  bit mon_en   = 1'b0;
  logic [512:0] exp_q[$];
  logic [512:0] got_q[$];
  logic [511:0] d;

  localparam logic [63:0] K_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  p4_out_pkt_collector dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .user_metadata_in(user_metadata_in), .user_metadata_in_valid(user_metadata_in_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_len(desc_len),
    .desc_beats(desc_beats), .desc_meta(desc_meta), .desc_err(desc_err),
    .pkt_active(pkt_active), .stat_pkt_count(stat_pkt_count), .stat_meta_drop(stat_meta_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Record forwarded beats that complete a handshake at the next rising edge.
  always @(negedge clk) begin
    if (mon_en && m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat, hold it until accepted (bounded), return 1 ns after the accepting edge.
  task automatic send(input logic [511:0] data, input logic [63:0] keep, input logic last);
    bit done;
    done = 1'b0;
    s_axis_tdata  = data;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (s_axis_tready) done = 1'b1;
      @(posedge clk); #1;
      if (tog_en) m_axis_tready = ~m_axis_tready;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk("send_accept", 512'(done), 512'd1);
    if (mon_en) exp_q.push_back({last, data});
  endtask

  task automatic push_meta(input logic [8:0] m);
    user_metadata_in       = m;
    user_metadata_in_valid = 1'b1;
    @(posedge clk); #1;
    user_metadata_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    user_metadata_in = '0; user_metadata_in_valid = 1'b0;
    m_axis_tready = 1'b1; desc_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset state
    chk("rst_tready", 512'(s_axis_tready), 512'd0);
    chk("rst_mvalid", 512'(m_axis_tvalid), 512'd0);
    chk("rst_dvalid", 512'(desc_valid), 512'd0);
    chk("rst_pktcnt", 512'(stat_pkt_count), 512'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", 512'(s_axis_tready), 512'd1);
    @(posedge clk); #1;

    // 1: single beat with metadata 5
    push_meta(9'h005);
    d = {16{32'hA5A5_0001}};
    send(d, K_ALL, 1'b1);
    @(negedge clk);
    chk("t1_mvalid", 512'(m_axis_tvalid), 512'd1);
    chk("t1_mdata", m_axis_tdata, d);
    chk("t1_mkeep", 512'(m_axis_tkeep), 512'(K_ALL));
    chk("t1_mlast", 512'(m_axis_tlast), 512'd1);
    chk("t1_dvalid", 512'(desc_valid), 512'd1);
    chk("t1_len", 512'(desc_len), 512'd64);
    chk("t1_beats", 512'(desc_beats), 512'd1);
    chk("t1_meta", 512'(desc_meta), 512'h005);
    chk("t1_err", 512'(desc_err), 512'd0);
    @(negedge clk);
    chk("t1_mvalid_drop", 512'(m_axis_tvalid), 512'd0);
    chk("t1_pktcnt", 512'(stat_pkt_count), 512'd1);
    @(posedge clk); #1;

    // 2: three beats, last tkeep 0x3FFF
    push_meta(9'h00A);
    chk("t2_active_pre", 512'(pkt_active), 512'd0);
    send({16{32'h0000_2001}}, K_ALL, 1'b0);
    @(negedge clk);
    chk("t2_active_b2", 512'(pkt_active), 512'd1);
    @(posedge clk); #1;
    send({16{32'h0000_2002}}, K_ALL, 1'b0);
    @(negedge clk);
    chk("t2_active_b3", 512'(pkt_active), 512'd1);
    @(posedge clk); #1;
    send({16{32'h0000_2003}}, 64'h3FFF, 1'b1);
    @(negedge clk);
    chk("t2_active_post", 512'(pkt_active), 512'd0);
    chk("t2_len", 512'(desc_len), 512'd142);
    chk("t2_beats", 512'(desc_beats), 512'd3);
    chk("t2_meta", 512'(desc_meta), 512'h00A);
    chk("t2_err", 512'(desc_err), 512'd0);
    @(posedge clk); #1;

    // 3: empty tkeep without metadata, then non-contiguous tkeep
    send({16{32'h0000_3001}}, 64'h0, 1'b1);
    @(negedge clk);
    chk("t3_len0", 512'(desc_len), 512'd0);
    chk("t3_meta0", 512'(desc_meta), 512'd0);
    chk("t3_err0", 512'(desc_err), 512'b010);
    @(posedge clk); #1;
    send({16{32'h0000_3002}}, 64'h5, 1'b1);
    @(negedge clk);
    chk("t3_len5", 512'(desc_len), 512'd2);
    chk("t3_err5", 512'(desc_err), 512'b011);
    @(posedge clk); #1;

    // 4: descriptor backpressure
    desc_ready = 1'b0;
    send({16{32'h0000_4001}}, 64'hF, 1'b1);
    s_axis_tdata = {16{32'h0000_4002}}; s_axis_tkeep = 64'hFF;
    s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    @(negedge clk);
    chk("t4_tready_lo1", 512'(s_axis_tready), 512'd0);
    chk("t4_hold_len", 512'(desc_len), 512'd4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_tready_lo2", 512'(s_axis_tready), 512'd0);
    chk("t4_hold_valid", 512'(desc_valid), 512'd1);
    desc_ready = 1'b1;
    #1;
    chk("t4_tready_hi", 512'(s_axis_tready), 512'd1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    @(negedge clk);
    chk("t4_reload_valid", 512'(desc_valid), 512'd1);
    chk("t4_reload_len", 512'(desc_len), 512'd8);
    chk("t4_pktcnt5", 512'(stat_pkt_count), 512'd5);
    @(negedge clk);
    chk("t4_pktcnt6", 512'(stat_pkt_count), 512'd6);
    chk("t4_dvalid_lo", 512'(desc_valid), 512'd0);
    @(posedge clk); #1;

    // 4b: m_axis_tready toggling across 5 packets (7 beats)
    mon_en = 1'b1; tog_en = 1'b1;
    send({16{32'hC0DE_0000}}, K_ALL, 1'b1);
    send({16{32'hC0DE_0001}}, K_ALL, 1'b0);
    send({16{32'hC0DE_0002}}, K_ALL, 1'b1);
    send({16{32'hC0DE_0003}}, K_ALL, 1'b1);
    send({16{32'hC0DE_0004}}, K_ALL, 1'b0);
    send({16{32'hC0DE_0005}}, K_ALL, 1'b1);
    send({16{32'hC0DE_0006}}, K_ALL, 1'b1);
    tog_en = 1'b0; m_axis_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("t4_out_count", 512'(got_q.size()), 512'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < got_q.size()) begin
        chk("t4_out_data", got_q[i][511:0], exp_q[i][511:0]);
        chk("t4_out_last", 512'(got_q[i][512]), 512'(exp_q[i][512]));
      end
    end

    // 5: FIFO overflow then in-order pairing
    for (int i = 1; i <= 5; i++) push_meta(9'(i));
    @(negedge clk);
    chk("t5_drop", 512'(stat_meta_drop), 512'd1);
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) begin
      send({16{32'h0000_5000}} + 512'(i), 64'h1, 1'b1);
      @(negedge clk);
      chk("t5_meta", 512'(desc_meta), 512'(i));
      chk("t5_err", 512'(desc_err), 512'd0);
      @(posedge clk); #1;
    end
    // Bypass: empty FIFO, push in the tlast cycle
    s_axis_tdata = {16{32'h0000_5555}}; s_axis_tkeep = 64'h3;
    s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    user_metadata_in = 9'h1AB; user_metadata_in_valid = 1'b1;
    @(negedge clk);
    chk("t5_byp_tready", 512'(s_axis_tready), 512'd1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; user_metadata_in_valid = 1'b0;
    @(negedge clk);
    chk("t5_byp_meta", 512'(desc_meta), 512'h1AB);
    chk("t5_byp_err", 512'(desc_err), 512'd0);
    @(posedge clk); #1;
    send({16{32'h0000_5556}}, 64'h3, 1'b1);
    @(negedge clk);
    chk("t5_after_byp_meta", 512'(desc_meta), 512'd0);
    chk("t5_after_byp_err", 512'(desc_err), 512'b010);
    @(posedge clk); #1;

    // 6: reset in the middle of a packet
    send({16{32'h0000_6001}}, K_ALL, 1'b0);
    send({16{32'h0000_6002}}, K_ALL, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_tready", 512'(s_axis_tready), 512'd0);
    chk("t6_mvalid", 512'(m_axis_tvalid), 512'd0);
    chk("t6_active", 512'(pkt_active), 512'd0);
    chk("t6_dvalid", 512'(desc_valid), 512'd0);
    chk("t6_pktcnt", 512'(stat_pkt_count), 512'd0);
    chk("t6_drop", 512'(stat_meta_drop), 512'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    send({16{32'h0000_6003}}, 64'hFF, 1'b1);
    @(negedge clk);
    chk("t6_len", 512'(desc_len), 512'd8);
    chk("t6_beats", 512'(desc_beats), 512'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
